// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_CNT_HI,
    S_CNT_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  localparam int CNT_WIDTH      = 16;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_SHIFT     = 2;

endpackage

// File: rtl/imem_loader_word_asm.sv
// rtl/imem_loader_word_asm.sv - big-endian 4-byte assembly register with lane counter.
module loader_word_asm
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        shift_en,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_out,
  output logic        word_full
);

  localparam int LANE_W = $clog2(BYTES_PER_WORD);

  logic [LANE_W-1:0] lane;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lane     <= '0;
      word_out <= '0;
    end else if (shift_en) begin
      lane     <= lane + LANE_W'(1);
      word_out <= {word_out[23:0], byte_in};
    end
  end

  // Flags the accept that completes the word, so the FSM can move to S_WRITE on the same edge.
  assign word_full = shift_en && (lane == LANE_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream boot loader for instruction memory; IMEM_LOADER_CHECKSUM_EN adds a trailing XOR byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_reset,
  output logic                  done,
  output logic                  error
);

  state_t               state;
  logic [7:0]           count_hi;
  logic [CNT_WIDTH-1:0] count;
  logic [CNT_WIDTH-1:0] index;
  logic                 we_q;
  logic                 accept;
  logic                 word_full;
  logic [31:0]          word;
  logic [CNT_WIDTH-1:0] count_rx;

  assign accept   = byte_valid && byte_ready;
  assign count_rx = {count_hi, byte_data};

  loader_word_asm u_word_asm (
    .clk      (clk),
    .reset    (reset),
    .shift_en (accept && (state == S_DATA)),
    .clear    (accept && (state == S_CNT_LO)),
    .byte_in  (byte_data),
    .word_out (word),
    .word_full(word_full)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk) begin
    if (reset || (state == S_CNT_HI)) begin
      csum <= '0;
    end else if (accept && (state == S_DATA)) begin
      csum <= csum ^ byte_data;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_CNT_HI;
      count_hi   <= '0;
      count      <= '0;
      index      <= '0;
      byte_ready <= 1'b1;
      we_q       <= 1'b0;
      imem_addr  <= '0;
      core_reset <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state)
        S_CNT_HI: begin
          if (accept) begin
            count_hi <= byte_data;
            state    <= S_CNT_LO;
          end
        end
        S_CNT_LO: begin
          if (accept) begin
            if ((count_rx == '0) || (int'(count_rx) > MAX_WORDS)) begin
              state      <= S_ERR;
              byte_ready <= 1'b0;
              error      <= 1'b1;
            end else begin
              count <= count_rx;
              index <= '0;
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (word_full) begin
            state      <= S_WRITE;
            byte_ready <= 1'b0;
            we_q       <= 1'b1;
            imem_addr  <= ADDR_WIDTH'(index) << WORD_SHIFT;
          end
        end
        S_WRITE: begin
          index <= index + CNT_WIDTH'(1);
          if ((index + CNT_WIDTH'(1)) == count) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state      <= S_CSUM;
            byte_ready <= 1'b1;
`else
            state      <= S_DONE;
            done       <= 1'b1;
            core_reset <= 1'b0;
`endif
          end else begin
            state      <= S_DATA;
            byte_ready <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (accept) begin
            byte_ready <= 1'b0;
            if (byte_data == csum) begin
              state      <= S_DONE;
              done       <= 1'b1;
              core_reset <= 1'b0;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
        end
`endif
        S_DONE, S_ERR: begin
          byte_ready <= 1'b0;
        end
        default: begin
          state      <= S_CNT_HI;
          byte_ready <= 1'b1;
        end
      endcase
    end
  end

  // Gating with reset guarantees no write escapes in a reset cycle, even one landing on S_WRITE.
  assign imem_we    = we_q & ~reset;
  assign imem_wdata = word;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader against a stream-level write model.
module tb_imem_loader;

  localparam int MAXW = 256;

  logic        clk;
  logic        reset;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_reset;
  logic        done;
  logic        error;

  int vectors = 0;
  int fails   = 0;
  logic [63:0] wq[$];

  imem_loader #(.ADDR_WIDTH(32), .MAX_WORDS(MAXW)) dut (
    .clk       (clk),
    .reset     (reset),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .core_reset(core_reset),
    .done      (done),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Records every write the memory would see, sampled mid-cycle.
  always @(negedge clk) begin
    #2;
    if (imem_we === 1'b1) begin
      wq.push_back({imem_addr, imem_wdata});
      check("ready_in_write", 64'(byte_ready), 64'(0));
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    byte_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // stall < 0: exactly one idle cycle before each byte; otherwise percent chance of idle cycles.
  task automatic send(input logic [7:0] b, input int stall);
    int guard;
    if (stall < 0) begin
      byte_valid = 1'b0;
      @(negedge clk);
    end else begin
      while ($urandom_range(99) < stall) begin
        byte_valid = 1'b0;
        @(negedge clk);
      end
    end
    byte_valid = 1'b1;
    byte_data  = b;
    guard = 0;
    while (byte_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      vectors++;
      fails++;
      $error("FAIL accept_timeout byte=%h ready=%b required=1", b, byte_ready);
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_load(input logic [31:0] w[$], input int stall, input logic bad_csum);
    logic [15:0] n;
    logic [7:0]  x;
    n = 16'(w.size());
    x = 8'h00;
    send(n[15:8], stall);
    send(n[7:0], stall);
    for (int i = 0; i < w.size(); i++) begin
      for (int j = 0; j < 4; j++) begin
        x = x ^ w[i][31-8*j -: 8];
        send(w[i][31-8*j -: 8], stall);
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(x ^ {7'd0, bad_csum}, stall);
`else
    if (bad_csum) x = ~x;
`endif
  endtask

  task automatic wait_end();
    int g;
    g = 0;
    while (done !== 1'b1 && error !== 1'b1 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 2000) begin
      vectors++;
      fails++;
      $error("FAIL end_timeout done=%b error=%b required=1", done, error);
    end
  endtask

  task automatic check_writes(input string tag, input logic [31:0] w[$]);
    @(negedge clk);
    #3;
    check({tag, "_count"}, 64'(wq.size()), 64'(w.size()));
    for (int i = 0; i < w.size() && i < wq.size(); i++)
      check(tag, wq[i], {32'(i * 4), w[i]});
    wq.delete();
  endtask

  initial begin
    logic [31:0] ws[$];

    reset = 1'b1;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(byte_ready), 64'(1));
    check("rst_we", 64'(imem_we), 64'(0));
    check("rst_addr", 64'(imem_addr), 64'(0));
    check("rst_wdata", 64'(imem_wdata), 64'(0));
    check("rst_core_reset", 64'(core_reset), 64'(1));
    check("rst_done", 64'(done), 64'(0));
    check("rst_error", 64'(error), 64'(0));
    reset = 1'b0;

    ws = '{32'h8C020004, 32'hAC020004};
    send_load(ws, 0, 1'b0);
`ifndef IMEM_LOADER_CHECKSUM_EN
    check("norm_we_last", 64'(imem_we), 64'(1));
    check("norm_done_early", 64'(done), 64'(0));
    @(negedge clk);
`else
    wait_end();
`endif
    check("norm_done", 64'(done), 64'(1));
    check("norm_core_reset", 64'(core_reset), 64'(0));
    check("norm_error", 64'(error), 64'(0));
    check_writes("norm_wr", ws);

    byte_valid = 1'b1;
    byte_data  = 8'h55;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("term_ready", 64'(byte_ready), 64'(0));
      check("term_done", 64'(done), 64'(1));
    end
    byte_valid = 1'b0;
    ws = {};
    check_writes("term_wr", ws);

    do_reset();
    ws = '{32'h8C020004, 32'hAC020004};
    send_load(ws, -1, 1'b0);
    wait_end();
    check("stall_done", 64'(done), 64'(1));
    check_writes("stall_wr", ws);

    do_reset();
    send(8'h00, 0);
    send(8'h00, 0);
    check("n0_error", 64'(error), 64'(1));
    check("n0_core_reset", 64'(core_reset), 64'(1));
    check("n0_ready", 64'(byte_ready), 64'(0));
    byte_valid = 1'b1;
    repeat (3) @(negedge clk);
    byte_valid = 1'b0;
    check("err_hold", 64'(error), 64'(1));
    ws = {};
    check_writes("n0_wr", ws);

    do_reset();
    send(8'h01, 0);
    send(8'h01, 0);
    check("nbig_error", 64'(error), 64'(1));
    check("nbig_done", 64'(done), 64'(0));

    do_reset();
    ws = {};
    for (int i = 0; i < MAXW; i++) ws.push_back($urandom);
    send_load(ws, 0, 1'b0);
    wait_end();
    check("nmax_done", 64'(done), 64'(1));
    check("nmax_last_addr", 64'(wq.size() == MAXW ? wq[MAXW-1][63:32] : 32'hFFFF_FFFF), 64'(32'h3FC));
    check_writes("nmax_wr", ws);

    do_reset();
    send(8'h00, 0);
    send(8'h02, 0);
    send(8'h8C, 0); send(8'h02, 0); send(8'h00, 0); send(8'h04, 0);
    send(8'hAC, 0); send(8'h02, 0); send(8'h00, 0);
    byte_valid = 1'b1;
    byte_data  = 8'h04;
    reset      = 1'b1;
    @(negedge clk);
    reset      = 1'b0;
    byte_valid = 1'b0;
    check("mid_we", 64'(imem_we), 64'(0));
    check("mid_ready", 64'(byte_ready), 64'(1));
    check("mid_core_reset", 64'(core_reset), 64'(1));
    check("mid_done", 64'(done), 64'(0));
    ws = '{32'h8C020004};
    check_writes("mid_wr", ws);
    ws = '{32'h20020004};
    send_load(ws, 0, 1'b0);
    wait_end();
    check("fresh_done", 64'(done), 64'(1));
    check_writes("fresh_wr", ws);

`ifdef IMEM_LOADER_CHECKSUM_EN
    do_reset();
    ws = '{32'h8C020004, 32'hAC020004};
    send_load(ws, 0, 1'b1);
    wait_end();
    check("csum_bad_error", 64'(error), 64'(1));
    check("csum_bad_core_reset", 64'(core_reset), 64'(1));
    check_writes("csum_bad_wr", ws);
`endif

    for (int it = 0; it < 5; it++) begin
      do_reset();
      ws = {};
      for (int i = 0; i < $urandom_range(6, 1); i++) ws.push_back($urandom);
      send_load(ws, 30, 1'b0);
      wait_end();
      check("rnd_done", 64'(done), 64'(1));
      check("rnd_core_reset", 64'(core_reset), 64'(0));
      check_writes("rnd_wr", ws);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
